// File: rtl/fifo_cdc_pkg.sv
// Shared helpers for the async FIFO pointer crossing: Gray/binary conversion
// and the Gray "full" pattern, used by both the gray counter and the receiver.
package fifo_cdc_pkg;

    localparam int unsigned PTR_W_MAX = 16;

    typedef logic [PTR_W_MAX-1:0] ptr_wide_t;

    typedef enum logic {
        SIDE_RD = 1'b0,
        SIDE_WR = 1'b1
    } side_e;

    function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
        ptr_wide_t b;
        b = g;
        for (int unsigned i = 1; i < PTR_W_MAX; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // Gray of (bin + depth) for a w-bit pointer: invert the top two Gray bits.
    function automatic ptr_wide_t full_pattern(input ptr_wide_t g, input int unsigned w);
        return g ^ (ptr_wide_t'(2'b11) << (w - 2));
    endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchronizer for a Gray-coded bus; also exposes the D-value of the
// final stage so downstream logic can register results on the same edge.
module cdc_sync_bus #(
    parameter int unsigned W      = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] q_next
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][W-1:0] stage;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q      = stage[STAGES-1];
    assign q_next = stage[STAGES-2];

endmodule

// File: rtl/fifo_ptr_receiver.sv
// Local-clock receiver of the remote Gray pointer: synchronizes, decodes and
// compares it with the local pointer to give empty/full, level and almost.
module fifo_ptr_receiver
    import fifo_cdc_pkg::*;
#(
    parameter int unsigned N             = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned WRITE_SIDE    = 0,
    parameter int unsigned ALMOST_MARGIN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] remote_ptr,
    input  logic [N-1:0] local_ptr_next,
    output logic [N-1:0] remote_ptr_sync,
    output logic [N-1:0] remote_bin,
    output logic         flag,
    output logic         almost,
    output logic [N-1:0] level
);

    localparam side_e        SIDE        = (WRITE_SIDE != 0) ? SIDE_WR : SIDE_RD;
    localparam logic [N-1:0] MARGIN      = N'(ALMOST_MARGIN);
    localparam logic [N-1:0] FULL_THRESH = N'((2 ** (N - 1)) - ALMOST_MARGIN);
    localparam logic         RESET_FLAG  = (SIDE == SIDE_RD);

    logic [N-1:0] sync_next;
    logic [N-1:0] local_bin;
    logic [N-1:0] sync_bin_next;
    logic [N-1:0] level_next;
    logic         flag_next;
    logic         almost_next;

    cdc_sync_bus #(
        .W      (N),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (remote_ptr),
        .q      (remote_ptr_sync),
        .q_next (sync_next)
    );

    // Compare against the values both pointers take at this edge, so the
    // registered flag moves together with the local pointer register.
    always_comb begin
        local_bin     = N'(gray2bin(ptr_wide_t'(local_ptr_next)));
        sync_bin_next = N'(gray2bin(ptr_wide_t'(sync_next)));
        level_next    = '0;
        flag_next     = 1'b0;
        almost_next   = 1'b0;
        if (SIDE == SIDE_WR) begin
            level_next  = local_bin - sync_bin_next;
            flag_next   = (local_ptr_next == N'(full_pattern(ptr_wide_t'(sync_next), N)));
            almost_next = (level_next >= FULL_THRESH);
        end else begin
            level_next  = sync_bin_next - local_bin;
            flag_next   = (local_ptr_next == sync_next);
            almost_next = (level_next <= MARGIN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remote_bin <= '0;
            level      <= '0;
            flag       <= RESET_FLAG;
            almost     <= RESET_FLAG;
        end else begin
            remote_bin <= N'(gray2bin(ptr_wide_t'(remote_ptr_sync)));
            level      <= level_next;
            flag       <= flag_next;
            almost     <= almost_next;
        end
    end

endmodule

// File: tb/tb_fifo_ptr_receiver.sv
// Self-checking bench: a read-side and a write-side receiver driven from
// unbounded binary pointers, compared every cycle against an occupancy model.
module tb_fifo_ptr_receiver;

    localparam int RD_S = 2;
    localparam int WR_S = 3;
    localparam int RD_M = 1;
    localparam int WR_M = 2;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rd_remote_g, rd_local_g, wr_remote_g, wr_local_g;
    logic [3:0] rd_sync, rd_bin, rd_level;
    logic [3:0] wr_sync, wr_bin, wr_level;
    logic       rd_flag, rd_almost, wr_flag, wr_almost;

    int rd_rem = 0, rd_loc = 0, wr_rem = 0, wr_loc = 0;
    int rd_hist[MAXC], rd_lh[MAXC], wr_hist[MAXC], wr_lh[MAXC];
    bit rst_at[MAXC];
    int cyc = 0;
    int n_checks = 0, n_errors = 0;

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    assign rd_remote_g = gray4(rd_rem);
    assign rd_local_g  = gray4(rd_loc);
    assign wr_remote_g = gray4(wr_rem);
    assign wr_local_g  = gray4(wr_loc);

    always #5 clk = ~clk;

    fifo_ptr_receiver #(.N(4), .SYNC_STAGES(RD_S), .WRITE_SIDE(0), .ALMOST_MARGIN(RD_M)) u_rd (
        .clk(clk), .rst_n(rst_n), .remote_ptr(rd_remote_g), .local_ptr_next(rd_local_g),
        .remote_ptr_sync(rd_sync), .remote_bin(rd_bin), .flag(rd_flag),
        .almost(rd_almost), .level(rd_level)
    );

    fifo_ptr_receiver #(.N(4), .SYNC_STAGES(WR_S), .WRITE_SIDE(1), .ALMOST_MARGIN(WR_M)) u_wr (
        .clk(clk), .rst_n(rst_n), .remote_ptr(wr_remote_g), .local_ptr_next(wr_local_g),
        .remote_ptr_sync(wr_sync), .remote_bin(wr_bin), .flag(wr_flag),
        .almost(wr_almost), .level(wr_level)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Remote pointer visible locally after edge k: value present SYNC_STAGES-1
    // edges earlier, or zero if a reset edge fell inside that window.
    function automatic int seen_raw(input bit wr, input int k);
        int s, j;
        s = wr ? WR_S : RD_S;
        j = k - s + 1;
        if (j < 0) return 0;
        for (int i = j; i <= k; i++) if (rst_at[i]) return 0;
        return wr ? wr_hist[j] : rd_hist[j];
    endfunction

    task automatic check_side(input bit wr, input int k, input logic [3:0] sync,
                              input logic [3:0] bin, input logic [3:0] lvl,
                              input logic fl, input logic al);
        int sb, pb, lb, el;
        bit ef, ea;
        sb = seen_raw(wr, k) & 15;
        pb = (k >= 1 && !rst_at[k]) ? (seen_raw(wr, k - 1) & 15) : 0;
        if (rst_at[k]) begin
            el = 0;
            ef = !wr;
            ea = !wr;
        end else begin
            lb = (wr ? wr_lh[k] : rd_lh[k]) & 15;
            el = wr ? ((lb - sb) & 15) : ((sb - lb) & 15);
            ef = wr ? (el == 8) : (el == 0);
            ea = wr ? (el >= 8 - WR_M) : (el <= RD_M);
        end
        chk(wr ? "wr_sync" : "rd_sync", int'(sync), int'(gray4(sb)));
        chk(wr ? "wr_bin" : "rd_bin", int'(bin), pb);
        chk(wr ? "wr_level" : "rd_level", int'(lvl), el);
        chk(wr ? "wr_flag" : "rd_flag", int'(fl), int'(ef));
        chk(wr ? "wr_almost" : "rd_almost", int'(al), int'(ea));
    endtask

    always @(posedge clk) begin
        if (cyc < MAXC) begin
            rd_hist[cyc] = rd_rem;
            rd_lh[cyc]   = rd_loc;
            wr_hist[cyc] = wr_rem;
            wr_lh[cyc]   = wr_loc;
            rst_at[cyc]  = !rst_n;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cyc >= 1 && cyc <= MAXC) begin
            check_side(1'b0, cyc - 1, rd_sync, rd_bin, rd_level, rd_flag, rd_almost);
            check_side(1'b1, cyc - 1, wr_sync, wr_bin, wr_level, wr_flag, wr_almost);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sr, sw;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_rd_flag", int'(rd_flag), 1);
        chk("rst_rd_almost", int'(rd_almost), 1);
        chk("rst_rd_level", int'(rd_level), 0);
        chk("rst_rd_bin", int'(rd_bin), 0);
        chk("rst_wr_flag", int'(wr_flag), 0);
        chk("rst_wr_almost", int'(wr_almost), 0);

        // Read side: remote steps to bin 1 then 2, local held at 0.
        rst_n  = 1'b1;
        rd_rem = 1;
        tick();
        chk("rd_flag_stale", int'(rd_flag), 1);
        tick();
        chk("rd_flag_fall", int'(rd_flag), 0);
        chk("rd_level1", int'(rd_level), 1);
        chk("rd_almost1", int'(rd_almost), 1);
        chk("rd_sync1", int'(rd_sync), 1);
        rd_rem = 2;
        repeat (2) tick();
        chk("rd_level2", int'(rd_level), 2);
        chk("rd_almost2", int'(rd_almost), 0);
        chk("rd_sync2", int'(rd_sync), 3);

        // Write side: local at 8 against remote 0 is full.
        wr_loc = 8;
        tick();
        chk("wr_full_flag", int'(wr_flag), 1);
        chk("wr_full_level", int'(wr_level), 8);
        chk("wr_full_almost", int'(wr_almost), 1);
        wr_rem = 1;
        repeat (2) tick();
        chk("wr_full_stale", int'(wr_flag), 1);
        tick();
        chk("wr_unfull_flag", int'(wr_flag), 0);
        chk("wr_unfull_level", int'(wr_level), 7);
        chk("wr_unfull_almost", int'(wr_almost), 1);

        // Wrap: local 15 then 16 (Gray 0) against remote 9.
        wr_rem = 7;
        repeat (3) tick();
        chk("wr_level_lo", int'(wr_level), 1);
        wr_loc = 15;
        wr_rem = 9;
        tick();
        chk("wr_wrap_full", int'(wr_flag), 1);
        repeat (2) tick();
        chk("wr_wrap_l6", int'(wr_level), 6);
        wr_loc = 16;
        tick();
        chk("wr_wrap_l7", int'(wr_level), 7);
        chk("wr_wrap_sync", int'(wr_sync), 13);
        chk("wr_wrap_bin", int'(wr_bin), 9);

        // Reset mid-stream with the read side at level 5.
        rd_rem = 5;
        repeat (2) tick();
        chk("rd_level5", int'(rd_level), 5);
        rst_n = 1'b0;
        tick();
        chk("mid_rd_flag", int'(rd_flag), 1);
        chk("mid_rd_almost", int'(rd_almost), 1);
        chk("mid_rd_level", int'(rd_level), 0);
        chk("mid_rd_sync", int'(rd_sync), 0);
        chk("mid_rd_bin", int'(rd_bin), 0);
        chk("mid_wr_flag", int'(wr_flag), 0);
        rst_n = 1'b1;
        tick();
        chk("mid_rd_sync_hold", int'(rd_sync), 0);
        tick();
        chk("mid_rd_sync_back", int'(rd_sync), 7);
        chk("mid_rd_level_back", int'(rd_level), 5);
        repeat (2) tick();

        // Simultaneous local and remote increments keep level at 1.
        rd_loc = 4;
        tick();
        chk("sim_level_a", int'(rd_level), 1);
        rd_rem = 6;
        tick();
        chk("sim_level_b", int'(rd_level), 1);
        rd_loc = 5;
        tick();
        chk("sim_level_c", int'(rd_level), 1);
        chk("sim_flag", int'(rd_flag), 0);
        tick();
        chk("sim_level_d", int'(rd_level), 1);

        // Random traffic obeying the occupancy limits each side can see.
        for (int it = 0; it < 3000; it++) begin
            int fast;
            fast = (it / 400) % 2;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                repeat (4) tick();
            end else begin
                sr = seen_raw(1'b0, cyc);
                if (rd_loc < sr && $urandom_range(0, 3) < 2 + fast) rd_loc++;
                if (rd_rem < rd_loc + 8 && $urandom_range(0, 3) < 3 - fast) rd_rem++;
                sw = seen_raw(1'b1, cyc);
                if (wr_loc + 1 - sw <= 8 && $urandom_range(0, 3) < 3 - fast) wr_loc++;
                if (wr_rem < wr_loc && $urandom_range(0, 3) < 1 + 2 * fast) wr_rem++;
                tick();
            end
        end
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_receiver.md
Name: fifo_ptr_receiver

Overview:
- Local-clock end of an async FIFO pointer crossing. It consumes the Gray pointer that the remote domain's gray counter produces.
- Synchronizes that pointer into the local clock and decodes it Gray-to-binary.
- Compares it with the local pointer to produce a registered empty flag (read side) or full flag (write side), plus occupancy level and an almost flag.
- One instance sits in each clock domain of the FIFO, beside that domain's gray counter.

Parameters:
- N, 4, pointer width including wrap bit; FIFO depth = 2**(N-1); N >= 3.
- SYNC_STAGES, 2, synchronizer flop count on the remote pointer; allowed range 2..4.
- WRITE_SIDE, 0, 0 = read-domain instance (empty/almost_empty); 1 = write-domain instance (full/almost_full).
- ALMOST_MARGIN, 1, almost threshold in entries; allowed range 0 .. 2**(N-1)-1.

Ports:
- clk  in  1  local clock.
- rst_n  in  1  reset, synchronous, active-low.
- remote_ptr  in  N  Gray pointer from the remote domain; asynchronous to clk.
- local_ptr_next  in  N  Gray D-input of the local gray counter's ptr register, i.e. the pointer value after this edge.
- remote_ptr_sync  out  N  remote Gray pointer after the final sync stage.
- remote_bin  out  N  binary decode of remote_ptr_sync, registered.
- flag  out  1  empty (WRITE_SIDE=0) or full (WRITE_SIDE=1), registered.
- almost  out  1  almost_empty or almost_full, registered.
- level  out  N  entries in the FIFO as seen locally (0 .. 2**(N-1)), registered.

Behaviour:
- Reset (rst_n=0 at a clk edge): all sync stages, remote_ptr_sync, remote_bin and level go to 0.
  - WRITE_SIDE=0: flag=1, almost=1.
  - WRITE_SIDE=1: flag=0, almost=0.
  - Reset mid-operation has the same effect and wins over all other updates.
- Synchronizer:
  - Stage 1 samples remote_ptr every edge; each later stage samples the one before it.
  - remote_ptr_sync is the last stage, so a change is visible SYNC_STAGES edges after capture.
  - No logic between stages.
- Decode: remote_bin[N-1] = g[N-1]; remote_bin[i] = remote_bin[i+1] ^ g[i]. It is registered from the last sync stage, so remote_bin lags remote_ptr_sync by 1 cycle.
- Flag, computed from the D-value of the sync chain and local_ptr_next, registered:
  - empty when local_ptr_next == sync_next.
  - full when local_ptr_next == {~sync_next[N-1:N-2], sync_next[N-3:0]}.
  - Result: flag updates on the same edge the local pointer updates, with no extra cycle.
- Level: decode local_ptr_next to binary lb, then compute modulo 2**N, N bits, registered on the same edge as flag.
  - Read side: level = sync_bin_next - lb.
  - Write side: level = lb - sync_bin_next.
- Almost:
  - Read side: almost = (level_next <= ALMOST_MARGIN).
  - Write side: almost = (level_next >= 2**(N-1) - ALMOST_MARGIN).
- Consistency invariants:
  - flag=1 implies level == 0 (read side) or level == 2**(N-1) (write side).
  - flag=1 implies almost=1.
- Wrap-around: pointers wrap naturally at 2**N; level stays correct across wrap.
- Simultaneous events: a local increment and a remote change in the same cycle both take effect in that edge's computation.
- The flag is pessimistic only: a stale remote pointer may leave empty/full asserted longer, never deasserted early.
- No X propagation: remote_ptr changes at most one bit per remote edge (Gray), so a metastable stage-1 resolves to old or new value.

Decomposition:
- Shared package fifo_cdc_pkg holds:
  - gray2bin and bin2gray functions, shared with the gray counter.
  - the full-pattern function (invert top two Gray bits).
- Natural sub-module: cdc_sync_bus (N-wide, SYNC_STAGES-deep flop chain with synchronous active-low reset). It carries the CDC-waiver attributes in one place.

Test Plan:
- Reset with rst_n=0 for 3 cycles, WRITE_SIDE=0, N=4 -> flag=1, almost=1, level=0, remote_bin=0; WRITE_SIDE=1 -> flag=0, almost=0.
- Read side, remote_ptr stepped 0000→0001→0011 (bin 1,2), local_ptr_next=0 -> flag falls 2 edges after first change; level=1 then 2; almost (margin 1) 1 then 0.
- Write side, local_ptr_next=Gray(8)=1100, remote_ptr=0000 held -> flag=1, level=8, almost=1; remote_ptr→0001 -> flag=0, level=7 after SYNC_STAGES edges.
- Wrap: local bin 14→15→0, remote bin 2 (write side) -> level 12 (illegal >8, assert fires), then correct case local 15, remote 9 -> level 6; local 0 (wrapped), remote 9 -> level 7.
- Simultaneous: read side at level 1, local increments and remote increments on the same edge -> level stays 1, flag stays 0.
- Reset asserted mid-stream at level 5 -> next edge all outputs at reset values; sync stages cleared, so the remote value needs SYNC_STAGES edges to reappear.
